// File: rtl/uart_tx_fifo_if.sv
// CPU-side register bus for the UART transmitter: chip select, write strobe,
// register select, write byte and the registered status word.
interface uart_tx_fifo_if;
  logic        cs;
  logic        we;
  logic        addr;
  logic [7:0]  wdata;
  logic [31:0] rdata;

  modport master (output cs, we, addr, wdata, input rdata);
  modport slave  (input cs, we, addr, wdata, output rdata);
endinterface

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter with a circular byte FIFO. DATA writes push bytes,
// CTRL bit0 clears the sticky overflow flag, and a registered status word
// exposes full / drained / overflow / count.
module uart_tx_fifo #(
  parameter int CLKDIV     = 16,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic             clk,
  input  logic             reset,
  uart_tx_fifo_if.slave    bus,
  output logic             tx,
  output logic             busy
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [15:0]           TLOAD    = 16'(CLKDIV - 1);
  localparam logic [DEPTH_LOG2:0]   FULL_CNT = DEPTH[DEPTH_LOG2:0];
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = 1;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  logic [7:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic [31:0]           rdata_q, rdata_d;
  state_e                state_q, state_d;
  logic [15:0]           timer_q, timer_d;
  logic [2:0]            idx_q, idx_d;
  logic [7:0]            shift_q, shift_d;
  logic                  tx_q, tx_d;

  logic full, empty, wr_data, wr_ctrl, push, pop, bit_end;

  // Fullness/emptiness come from pre-edge count, so a push while full is
  // refused even if the transmitter pops on the same edge.
  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign wr_data = bus.cs & bus.we & ~bus.addr;
  assign wr_ctrl = bus.cs & bus.we &  bus.addr;
  assign push    = wr_data & ~full;
  assign bit_end = (timer_q == 16'd0);

  // FIFO pointers, occupancy and sticky overflow; a clear beats a same-edge overflow.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (push) wptr_d = wptr_q + PTR_ONE;
    if (pop)  rptr_d = rptr_q + PTR_ONE;
    if (push && !pop)      count_d = count_q + CNT_ONE;
    else if (!push && pop) count_d = count_q - CNT_ONE;
    if (wr_data && full)             ovf_d = 1'b1;
    if (wr_ctrl && bus.wdata[0])     ovf_d = 1'b0;
  end

  // Transmitter next state: each bit lasts CLKDIV cycles via a down-counter;
  // the stop bit chains straight into the next start bit when data is queued.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          shift_d = mem_q[rptr_q];
          state_d = S_START;
          timer_d = TLOAD;
          tx_d    = 1'b0;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          idx_d   = 3'd0;
          timer_d = TLOAD;
          tx_d    = shift_q[0];
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          timer_d = TLOAD;
          if (idx_q == 3'd7) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            shift_d = shift_q >> 1;
            idx_d   = idx_q + 3'd1;
            tx_d    = shift_q[1];
          end
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (!empty) begin
            pop     = 1'b1;
            shift_d = mem_q[rptr_q];
            state_d = S_START;
            timer_d = TLOAD;
            tx_d    = 1'b0;
          end else begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  // Status word built from pre-edge state; it appears one cycle after the cause.
  always_comb begin
    rdata_d                   = '0;
    rdata_d[0]                = full;
    rdata_d[1]                = empty && (state_q == S_IDLE);
    rdata_d[2]                = ovf_q;
    rdata_d[3 +: DEPTH_LOG2+1] = count_q;
  end

  // FIFO storage; contents need no reset since the count gates every read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= bus.wdata;
  end

  // FIFO bookkeeping and status register.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      rdata_q <= rdata_d;
    end
  end

  // Transmitter FSM state and registered line output.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  assign tx        = tx_q;
  assign busy      = !empty || (state_q != S_IDLE);
  assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed + randomized bench for uart_tx_fifo: a line monitor decodes 8N1
// frames from tx and is compared against the list of bytes the block should
// have accepted, plus directed checks of status, latency and reset behaviour.
module tb_uart_tx_fifo;
  localparam int CLKDIV = 4;
  localparam int DL2    = 3;
  localparam int DEPTH  = 1 << DL2;
  localparam int FRAME  = 10 * CLKDIV;

  logic clk = 1'b0;
  logic reset;
  logic tx, busy;

  uart_tx_fifo_if bus();

  uart_tx_fifo #(.CLKDIV(CLKDIV), .DEPTH_LOG2(DL2)) dut (
    .clk(clk), .reset(reset), .bus(bus), .tx(tx), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc     = 0;
  int rst_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  int         start_cyc[$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) rst_cnt <= rst_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic a, input logic [7:0] d);
    bus.cs = 1'b1; bus.we = 1'b1; bus.addr = a; bus.wdata = d;
    step();
    bus.cs = 1'b0; bus.we = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < budget) begin
      step();
      n++;
    end
    chk("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  task automatic check_rx(input string tag);
    int n;
    n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
    chk({tag, "_len"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_byte%0d", tag, i), {24'd0, rx_q[i]}, {24'd0, exp_q[i]});
    rx_q.delete();
    exp_q.delete();
  endtask

  // Line monitor: samples each bit mid-cell; frames cut by a reset are discarded.
  initial begin : monitor
    int         rc;
    logic [7:0] b;
    logic       st;
    forever begin
      @(negedge clk);
      if (tx === 1'b0) begin
        rc = rst_cnt;
        start_cyc.push_back(cyc);
        repeat (CLKDIV / 2) @(negedge clk);
        st = tx;
        for (int k = 0; k < 8; k++) begin
          repeat (CLKDIV) @(negedge clk);
          b[k] = tx;
        end
        repeat (CLKDIV) @(negedge clk);
        if (rc == rst_cnt) begin
          chk("start_bit", {31'd0, st}, 32'd0);
          chk("stop_bit", {31'd0, tx}, 32'd1);
          rx_q.push_back(b);
        end
        repeat (CLKDIV - CLKDIV / 2 - 1) @(negedge clk);
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [9:0]  fr;
    logic [7:0]  b, pair [2];
    int          lows, tmo, n;

    bus.cs = 1'b0; bus.we = 1'b0; bus.addr = 1'b0; bus.wdata = 8'h00;
    reset = 1'b1;
    repeat (3) step();
    chk("rst_tx", {31'd0, tx}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rdata", bus.rdata, 32'd0);
    reset = 1'b0;
    step();
    chk("rst_drained", bus.rdata, 32'h2);

    // Single byte: exact waveform, 2-clock first-bit latency.
    b = 8'h55;
    wr(1'b0, b);
    chk("s_tx_before", {31'd0, tx}, 32'd1);
    chk("s_busy", {31'd0, busy}, 32'd1);
    step();
    chk("s_rdata_cnt1", bus.rdata, 32'h0 | (1 << 3));
    fr = {1'b1, b, 1'b0};
    for (int i = 0; i < FRAME; i++) begin
      chk($sformatf("s_wave%0d", i), {31'd0, tx}, {31'd0, fr[i / CLKDIV]});
      step();
    end
    chk("s_busy_drop", {31'd0, busy}, 32'd0);
    step();
    chk("s_drained", bus.rdata, 32'h2);
    exp_q.push_back(b);
    step();
    check_rx("single");

    // Back-to-back frames: "AB" and then a random pair.
    for (int p = 0; p < 2; p++) begin
      pair[0] = (p == 0) ? 8'h41 : 8'($urandom);
      pair[1] = (p == 0) ? 8'h42 : 8'($urandom);
      start_cyc.delete();
      for (int i = 0; i < 2; i++) begin
        bus.cs = 1'b1; bus.we = 1'b1; bus.addr = 1'b0; bus.wdata = pair[i];
        exp_q.push_back(pair[i]);
        step();
      end
      bus.cs = 1'b0; bus.we = 1'b0;
      wait_idle(4 * FRAME);
      step(); step();
      chk("b2b_frames", start_cyc.size(), 32'd2);
      if (start_cyc.size() == 2)
        chk("b2b_gap", start_cyc[1] - start_cyc[0], FRAME);
      check_rx("b2b");
    end

    // Overflow burst: first DEPTH+1 bytes accepted (FIFO plus shift register).
    for (int i = 0; i < DEPTH + 2; i++) begin
      bus.cs = 1'b1; bus.we = 1'b1; bus.addr = 1'b0; bus.wdata = 8'(i);
      if (i <= DEPTH) exp_q.push_back(8'(i));
      step();
    end
    bus.cs = 1'b0; bus.we = 1'b0;
    chk("ovf_peak", bus.rdata, 32'h1 | (DEPTH << 3));
    step();
    chk("ovf_set", bus.rdata, 32'h1 | 32'h4 | (DEPTH << 3));
    wr(1'b1, 8'h01);
    chk("ovf_clr_lat", bus.rdata, 32'h1 | 32'h4 | (DEPTH << 3));
    step();
    chk("ovf_cleared", bus.rdata, 32'h1 | (DEPTH << 3));
    wait_idle((DEPTH + 2) * FRAME);
    step(); step();
    chk("ovf_drained", bus.rdata, 32'h2);
    check_rx("ovf");

    // Reset during the DATA state of the first byte with three more queued.
    b = 8'hA5;
    for (int i = 0; i < 4; i++) begin
      bus.cs = 1'b1; bus.we = 1'b1; bus.addr = 1'b0;
      bus.wdata = (i == 0) ? b : 8'($urandom);
      step();
    end
    bus.cs = 1'b0; bus.we = 1'b0;
    repeat (FRAME / 2) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mr_tx", {31'd0, tx}, 32'd1);
    chk("mr_busy", {31'd0, busy}, 32'd0);
    chk("mr_rdata0", bus.rdata, 32'd0);
    step();
    chk("mr_rdata2", bus.rdata, 32'h2);
    lows = 0;
    repeat (3 * FRAME) begin
      step();
      if (tx !== 1'b1) lows++;
    end
    chk("mr_line_quiet", lows, 32'd0);
    check_rx("midrst");

    // Stream 20 random bytes while polling the full flag; pointers wrap twice.
    tmo = 0;
    for (int i = 0; i < 20; i++) begin
      n = 0;
      while (bus.rdata[0] !== 1'b0 && n < 4 * FRAME) begin
        step();
        n++;
      end
      if (n >= 4 * FRAME) tmo++;
      b = 8'($urandom);
      exp_q.push_back(b);
      wr(1'b0, b);
      step();
      repeat ($urandom_range(0, 2)) step();
    end
    chk("wrap_poll_timeout", tmo, 32'd0);
    chk("wrap_ovf", {31'd0, bus.rdata[2]}, 32'd0);
    wait_idle(22 * FRAME);
    step(); step();
    chk("wrap_drained", bus.rdata, 32'h2);
    check_rx("wrap");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Memory-mapped 8N1 UART transmitter with an internal byte FIFO. It sits on the cpu32 data bus in the 0xE0000000 I/O window and takes the place of the simulation-only character printer. It accepts byte writes from the CPU, buffers them, and serialises them LSB-first on `tx`. A registered status word lets software poll for space and for drain completion.

## Interface
- `CLKDIV`, default 16: clock cycles per bit; legal range 2..65535.
- `DEPTH_LOG2`, default 3: log2 of FIFO depth; default depth is 8 bytes.
- `clk`  in  1: system clock; all state changes on the rising edge.
- `reset`  in  1: synchronous, active-high reset, sampled on the rising edge of `clk`.
- `cs`  in  1: chip select, driven from `d_addr[31:28] == 4'hE`.
- `we`  in  1: write strobe (`d_data_we`); a write occurs when `cs & we` on a rising edge.
- `addr`  in  1: register select (`d_addr[2]`). 0 = DATA, 1 = CTRL.
- `wdata`  in  8: write data (`d_data_w[7:0]`).
- `rdata`  out  32: registered status word.
- `tx`  out  1: serial output; idle high.
- `busy`  out  1: high while the FIFO is non-empty or a frame is in progress.

## Operation
- **DATA write** (`cs & we & addr==0`):
  - If the FIFO is not full, push `wdata`.
  - If the FIFO is full, drop the byte and set the sticky `ovf` flag.
  - Fullness is evaluated on pre-edge state, so a push while full is rejected even if a pop happens on the same edge.
- **CTRL write** (`cs & we & addr==1`):
  - `wdata[0]=1` clears `ovf`.
  - Other bits are ignored.
  - If an overflow and a clear occur on the same edge, the clear wins.
- **FIFO**:
  - Circular, `2**DEPTH_LOG2` entries, with read/write pointers of `DEPTH_LOG2` bits that wrap naturally.
  - Count is `DEPTH_LOG2+1` bits.
  - Simultaneous push and pop leaves the count unchanged.
- **Transmitter FSM**: states IDLE, START, DATA, STOP.
  - IDLE: `tx=1`. If the FIFO is non-empty (pre-edge count), pop into an 8-bit shift register and go to START.
  - START: `tx=0` for `CLKDIV` cycles, then go to DATA with bit index 0.
  - DATA: `tx=shift[0]` for `CLKDIV` cycles, then shift right and increment the index. After index 7 completes, go to STOP.
  - STOP: `tx=1` for `CLKDIV` cycles.
    - If the FIFO is non-empty on the final STOP cycle, pop and go directly to START, with no idle gap.
    - Otherwise go to IDLE.
- **Bit timer**: a down-counter loaded with `CLKDIV-1` on each bit entry. The bit ends when it reaches 0.
- **`rdata`** is updated every cycle from pre-edge state:
  - bit0 = FIFO full
  - bit1 = FIFO empty and FSM in IDLE (drained)
  - bit2 = `ovf`
  - bits[10:3] = FIFO count, zero-extended
  - other bits = 0
- **`tx`** is registered and glitch-free.
- **`busy`** = FIFO non-empty OR FSM not in IDLE. It is a combinational OR of registered state.

## Timing
- **Reset values**: `tx=1`, `busy=0`, `rdata=0`, FIFO empty, pointers 0, `ovf=0`, FSM in IDLE.
- **Reset mid-frame**: on the reset edge `tx` returns to 1 and queued bytes are discarded. `rdata` reads 0 on the cycle after the reset edge, then shows drained status (0x2) from the next cycle.
- **Write-to-start latency**: write at edge N into an empty, idle block. The byte is pushed at edge N, popped at edge N+1, and `tx` falls after edge N+1. First-bit latency is 2 clocks.
- **Frame length**: exactly `10*CLKDIV` cycles, from the `tx` fall to the end of the stop bit.
- **Back-to-back frames**: the next frame's start bit begins on the cycle after the previous stop bit's last cycle.
- **Status latency**: `rdata` reflects pushes, pops and `ovf` changes one cycle after the causing edge.
- **Capacity**: the shift register holds one byte in addition to the FIFO. After a burst of writes into an idle, empty block, at most `2**DEPTH_LOG2 + 1` bytes are accepted.

## Test plan
- **Single byte**: reset, then write DATA=0x55 with `CLKDIV=4`.
  - `tx` falls 2 clocks after the write.
  - The line carries 0,1,0,1,0,1,0,1,0,1, each held 4 cycles.
  - `busy` drops after 40 cycles.
  - `rdata`=0x2 afterwards.
- **Back-to-back frames**: write 0x41 then 0x42 on consecutive cycles.
  - Two contiguous 40-cycle frames with no idle high between stop and start.
  - The teleprinter-style monitor decodes "AB".
- **Overflow**: with `DEPTH_LOG2=3`, write 10 bytes (0x00..0x09) on consecutive cycles.
  - Bytes 0x00..0x08 are transmitted in order; 0x09 is dropped.
  - `rdata` bit2=1 and bit0=1 after the burst.
  - The count field reads 8 at its peak.
- **Overflow clear**: after the overflow scenario, write CTRL=0x1. `rdata` bit2 reads 0 on the next cycle and the FIFO contents are unaffected.
- **Reset mid-frame**: assert `reset` for 1 cycle during the DATA state of 0xA5 with 3 bytes queued.
  - `tx`=1 the cycle after.
  - No further frames are sent.
  - `rdata` reads 0 on the cycle after the reset edge, then 0x2.
- **Pointer wrap**: stream 20 bytes (0x30..0x43), keeping the FIFO non-full by polling `rdata` bit0.
  - All 20 bytes are received in order.
  - Pointers have wrapped at least twice.
  - `ovf` stays 0.
